rgb_sgen: RTL and testbench
===========================

# rgb_sgen

Serial RGB LED waveform generator: accepts 24-bit GRB words over a valid/ready handshake and emits them MSB-first as the one-wire NRZ stream (WS2812-style) that `rgb_sinp` decodes, plus on-demand "stream reset" low periods. It is the stage directly upstream of `rgb_sinp`. It sources stimulus for the full chain `rgb_sinp -> rgb_sbit2wrd -> async_fifo -> rgb_sotp` in loopback benches, and it drives RGB strips from on-chip pattern logic.

## Interface
- `T0H`, 38: clocks high for a 0 bit (~0.4 us at 96 MHz); must be < `rgb_sinp` `SAMPLE_TIME_CLKS` (57).
- `T0L`, 82: clocks low for a 0 bit.
- `T1H`, 77: clocks high for a 1 bit; must be > 57.
- `T1L`, 43: clocks low for a 1 bit.
- `RST_CLKS`, 5760: clocks low for a stream reset (~60 us); must be > `rgb_sinp` `STREAM_RESET_CLKS` (4800).
- `COUNTER_MAX`, 7800: counter ceiling; width = `$clog2(COUNTER_MAX+1)`. All timing parameters must be in 1..`COUNTER_MAX`.
- `clk` input, 1: single clock, 96 MHz nominal.
- `rst` input, 1: reset, asynchronous, active-low.
- `in_word` input, 24: GRB word, bit 23 sent first.
- `in_valid` input, 1: `in_word` is valid.
- `in_latch` input, 1: one-cycle pulse requesting a stream reset.
- `out_ready` output, 1: word accepted on the rising edge where `in_valid && out_ready`.
- `out_sig` output, 1: serial line, registered.
- `out_busy` output, 1: high whenever state is not IDLE.
- `out_latch_done` output, 1: one-cycle pulse in the last clock of a RESET period.

## Operation
- States:
  - IDLE: `out_sig` = 0.
  - HIGH: `out_sig` = 1, for `T0H`/`T1H` clocks.
  - LOW: `out_sig` = 0, for `T0L`/`T1L` clocks.
  - RESET: `out_sig` = 0, for `RST_CLKS` clocks.
- Registers: shift register (24), bit index (5), down-counter, `latch_pend`.
- Word boundary: IDLE, or the last clock of LOW for bit 0.
- `out_ready` = boundary && !`latch_pend` && reset deasserted.
- On acceptance, the word loads into the shift register and the state goes to HIGH for bit 23.
- HIGH to LOW after its count. LOW to HIGH for the next bit after its count.
- After bit 0's LOW, the next state is:
  - HIGH, if a new word is accepted on that edge;
  - RESET, if `latch_pend` is set;
  - IDLE, otherwise.
- `in_latch` in any state except RESET sets `latch_pend`. `latch_pend` clears on RESET entry. `in_latch` during RESET is ignored.
- A latch never truncates a word in flight. It takes effect at the next word boundary, and takes priority over a simultaneous `in_valid`.
- RESET to IDLE after `RST_CLKS` clocks. `out_latch_done` pulses in the final RESET clock.
- Reset values while `rst` = 0: state IDLE, `out_sig` 0, `out_ready` 0, `out_busy` 0, `out_latch_done` 0, `latch_pend` 0, counters 0.
- Asserting `rst` mid-word aborts immediately: the line drops low and the partial word is discarded.

## Timing
- Zero-latency start: the edge that accepts a word is the edge at which `out_sig` goes to 1.
- Bit period is exact:
  - 0 bit: high `T0H`, then low `T0L`.
  - 1 bit: high `T1H`, then low `T1L`.
  - No extra cycles between bits or between back-to-back words.
- Word duration = sum over 24 bits. With defaults, all-zero word = 2880 clocks; all-one word = 2880 clocks.
- Latch from IDLE: `in_latch` at edge k sets `latch_pend`. RESET is entered at edge k+1. `out_latch_done` is high in cycle k+`RST_CLKS`. IDLE (and `out_ready` = 1) follows at edge k+1+`RST_CLKS`.
- `in_word` is sampled only on the accepting edge and may change afterward.

## Configuration
- `RGB_SGEN_AUTO_LATCH_EN` defined: entering IDLE after a word's final bit with no accepted word sets `latch_pend` automatically. An idle gap therefore always becomes a full stream reset. A word offered during that boundary clock is still accepted, since auto-latch applies only on the IDLE transition.
- Not defined: stream resets occur only via `in_latch`; IDLE holds the line low indefinitely.

## Test plan
- Single word: word 0xA500FF with defaults, then IDLE. Check:
  - `out_sig` pulses: 1,0,1,0,0,1,0,1 (highs of 77/38 clocks), then eight 0 bits, then eight 1 bits.
  - `out_busy` high for exactly 2880 clocks.
- Back-to-back: `in_valid` held with words 0xFFFFFF then 0x000000. Check:
  - second acceptance occurs on the final LOW clock of the first word's bit 0;
  - the rising edge of bit 23 of word 2 immediately follows the 43rd low clock, with no gap.
- Latch priority: `in_latch` pulse mid-word while `in_valid` is held. Check:
  - the current word completes;
  - `out_ready` stays 0 at the boundary and 5760 low clocks follow;
  - `out_latch_done` pulses once;
  - the next word starts one clock after RESET ends.
- Reset mid-word: `rst` low at bit 10 of word 0xFFFFFF. Check `out_sig`, `out_ready`, and `out_busy` go to 0 asynchronously; after release, IDLE with `out_ready` = 1 and no residual bits.
- Loopback: `out_sig` into `rgb_sinp`/`rgb_sbit2wrd` (`RGB_SGEN_AUTO_LATCH_EN` off), sending 0x123456, latch, 0xABCDEF. Check exactly those words appear, and `rgb_sinp` flags `stream_reset` once per latch.
- Auto-latch: `RGB_SGEN_AUTO_LATCH_EN` on, one word with no follow-up. Check a 5760-clock low period and an `out_latch_done` pulse without any `in_latch`.

Source files
------------

// File: rtl/rgb_sgen.sv
// rgb_sgen: WS2812-style serial RGB waveform generator (24-bit GRB words, MSB first, plus stream-reset lows).
// Define RGB_SGEN_AUTO_LATCH_EN to turn every idle gap after a word into a full stream reset.
module rgb_sgen #(
  parameter int T0H         = 38,
  parameter int T0L         = 82,
  parameter int T1H         = 77,
  parameter int T1L         = 43,
  parameter int RST_CLKS    = 5760,
  parameter int COUNTER_MAX = 7800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_word,
  input  logic        in_valid,
  input  logic        in_latch,
  output logic        out_ready,
  output logic        out_sig,
  output logic        out_busy,
  output logic        out_latch_done
);
  localparam int CW = $clog2(COUNTER_MAX + 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, RESET} state_t;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [23:0]    sr;
  logic [4:0]     idx;
  logic           latch_pend;
  logic           last, boundary, accept;
  function automatic logic [CW-1:0] hi_len(input logic b);
    return b ? CW'(T1H - 1) : CW'(T0H - 1);
  endfunction
  function automatic logic [CW-1:0] lo_len(input logic b);
    return b ? CW'(T1L - 1) : CW'(T0L - 1);
  endfunction
  assign last           = cnt == '0;
  assign boundary       = state == IDLE || (state == LOW && last && idx == '0);
  assign out_ready      = boundary && !latch_pend && rst;
  assign accept         = in_valid && out_ready;
  assign out_busy       = state != IDLE;
  assign out_latch_done = state == RESET && last;
  // The counter holds "clocks remaining minus one" so a phase of N clocks ends when it reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      idx        <= '0;
      latch_pend <= 1'b0;
      out_sig    <= 1'b0;
    end else if (accept) begin
      state   <= HIGH;
      sr      <= in_word;
      idx     <= 5'd23;
      cnt     <= hi_len(in_word[23]);
      out_sig <= 1'b1;
      if (in_latch) latch_pend <= 1'b1;
    end else if (boundary && latch_pend) begin
      state      <= RESET;
      cnt        <= CW'(RST_CLKS - 1);
      out_sig    <= 1'b0;
      latch_pend <= 1'b0;
    end else begin
      if (in_latch && state != RESET) latch_pend <= 1'b1;
      case (state)
        IDLE: ;
        HIGH:
          if (last) begin
            state   <= LOW;
            cnt     <= lo_len(sr[23]);
            out_sig <= 1'b0;
          end else cnt <= cnt - 1'b1;
        LOW:
          if (last) begin
            if (idx == '0) begin
              state <= IDLE;
`ifdef RGB_SGEN_AUTO_LATCH_EN
              latch_pend <= 1'b1;
`else
`endif
            end else begin
              state   <= HIGH;
              sr      <= {sr[22:0], 1'b0};
              idx     <= idx - 1'b1;
              cnt     <= hi_len(sr[22]);
              out_sig <= 1'b1;
            end
          end else cnt <= cnt - 1'b1;
        RESET:
          if (last) state <= IDLE;
          else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rgb_sgen.sv
// tb_rgb_sgen: random-word bench for rgb_sgen against a per-clock expected-waveform model.
module tb_rgb_sgen;
  localparam int T0H = 38, T0L = 82, T1H = 77, T1L = 43, RST_CLKS = 5760;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_word;
  logic        in_valid, in_latch;
  logic        out_ready, out_sig, out_busy, out_latch_done;
  int          checks = 0;
  int          errors = 0;
  typedef struct packed {logic sig, busy, ready, done;} smp_t;
  smp_t exp_q[$];

  rgb_sgen dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_latch(in_latch),
    .out_ready(out_ready), .out_sig(out_sig), .out_busy(out_busy), .out_latch_done(out_latch_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void add_n(input int n, input smp_t s);
    for (int j = 0; j < n; j++) exp_q.push_back(s);
  endfunction

  // A word is 24 bit periods, each a high run then a low run; ready only at the final low clock.
  function automatic void add_word(input logic [23:0] w, input logic ready_last);
    for (int b = 23; b >= 0; b--) begin
      add_n(w[b] ? T1H : T0H, '{1'b1, 1'b1, 1'b0, 1'b0});
      add_n((w[b] ? T1L : T0L) - 1, '{1'b0, 1'b1, 1'b0, 1'b0});
      exp_q.push_back('{1'b0, 1'b1, b == 0 ? ready_last : 1'b0, 1'b0});
    end
  endfunction

  function automatic void add_reset();
    add_n(RST_CLKS - 1, '{1'b0, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b1});
  endfunction

  function automatic void add_tail();
`ifdef RGB_SGEN_AUTO_LATCH_EN
    add_n(1, '{1'b0, 1'b0, 1'b0, 1'b0});
    add_reset();
`endif
    add_n(1, '{1'b0, 1'b0, 1'b1, 1'b0});
  endfunction

  task automatic drain(input string tn, input int drop_at, input int latch_at, input logic [23:0] nxt);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s sig@%0d", tn, i), out_sig, exp_q[i].sig);
      chk($sformatf("%s busy@%0d", tn, i), out_busy, exp_q[i].busy);
      chk($sformatf("%s ready@%0d", tn, i), out_ready, exp_q[i].ready);
      chk($sformatf("%s done@%0d", tn, i), out_latch_done, exp_q[i].done);
      if (i == 0) in_word = nxt;
      if (i == drop_at) in_valid = 1'b0;
      in_latch = (i == latch_at);
    end
    exp_q.delete();
  endtask

  task automatic start_word(input string tn, input logic [23:0] w);
    @(negedge clk);
    chk({tn, " ready_idle"}, out_ready, 1'b1);
    in_word  = w;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [23:0] w1, w2;
    int          l1;
    rst = 1'b0; in_word = '0; in_valid = 1'b0; in_latch = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst sig", out_sig, 1'b0);
    chk("rst ready", out_ready, 1'b0);
    chk("rst busy", out_busy, 1'b0);
    chk("rst done", out_latch_done, 1'b0);
    rst = 1'b1;

    // single words: the fixed pattern and random ones, in_word scrambled after acceptance
    for (int k = 0; k < 3; k++) begin
      w1 = (k == 0) ? 24'hA500FF : 24'($urandom);
      start_word("single", w1);
      add_word(w1, 1'b1);
      add_tail();
      drain("single", 0, -1, 24'($urandom));
    end

    // back-to-back: in_valid held, second word accepted on the last low clock of the first
    w1 = 24'($urandom) | 24'h000001;
    w2 = 24'($urandom);
    start_word("b2b", w1);
    add_word(w1, 1'b1);
    l1 = exp_q.size();
    add_word(w2, 1'b1);
    add_tail();
    drain("b2b", l1, -1, w2);

    // latch mid-word with in_valid held: word completes, reset, then next word
    w1 = 24'($urandom);
    w2 = 24'($urandom);
    start_word("latchprio", w1);
    add_word(w1, 1'b0);
    add_reset();
    l1 = exp_q.size();
    add_n(1, '{1'b0, 1'b0, 1'b1, 1'b0});
    add_word(w2, 1'b1);
    add_tail();
    drain("latchprio", l1 + 1, 500, w2);

    // latch from idle: pend at edge k, reset from k+1, done at k+RST_CLKS
    @(negedge clk);
    chk("latchidle ready0", out_ready, 1'b1);
    in_latch = 1'b1;
    add_n(1, '{1'b0, 1'b0, 1'b0, 1'b0});
    add_reset();
    add_n(1, '{1'b0, 1'b0, 1'b1, 1'b0});
    drain("latchidle", -1, -1, '0);

    // asynchronous reset during bit 10 of an all-ones word
    start_word("abort", 24'hFFFFFF);
    for (int i = 0; i <= 13 * 120 + 30; i++) begin
      @(negedge clk);
      if (i == 0) in_valid = 1'b0;
    end
    chk("abort sig_before", out_sig, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort sig", out_sig, 1'b0);
    chk("abort ready", out_ready, 1'b0);
    chk("abort busy", out_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    add_n(300, '{1'b0, 1'b0, 1'b1, 1'b0});
    drain("abort_after", -1, -1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
